// File: rtl/spdif_aes3_receiver.sv
// spdif_aes3_receiver: decodes a biphase-mark S/PDIF-AES3 stream (one half-cell per clk) into stereo pairs.
// Define RX_SYNC_EN to put a 2-flop synchronizer plus an edge-aligning flop ahead of the decoder.
module spdif_aes3_receiver #(
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_i,
    output logic [2*SAMPLE_WIDTH-1:0] sample_o,
    output logic                      valid_o,
    output logic                      block_start_o,
    output logic [1:0]                vbit_o,
    output logic [1:0]                ubit_o,
    output logic [1:0]                cbit_o,
    output logic [7:0]                frame_idx_o,
    output logic                      locked_o,
    output logic                      parity_err_o,
    output logic                      code_err_o
);

    generate
        if (SAMPLE_WIDTH != 16 && SAMPLE_WIDTH != 20 && SAMPLE_WIDTH != 24) begin : g_bad_width
            $error("spdif_aes3_receiver: SAMPLE_WIDTH must be 16, 20 or 24");
        end
    endgenerate

    typedef enum logic [1:0] {HUNT, DATA, PRE} state_t;
    typedef enum logic [1:0] {PT_NONE, PT_X, PT_Y, PT_Z} pre_t;

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] sample;
        logic                    v;
        logic                    u;
        logic                    c;
        logic                    z;
        logic                    ok;
    } sub_t;

    state_t      state, state_n;
    pre_t        cur_type, win_type;
    sub_t        left;
    logic        rx_in, rx_q, last_hc, h0_q, half, par;
    logic        vb, ub, cb, have_left;
    logic [7:0]  win, win_n;
    logic [2:0]  win_cnt;
    logic [4:0]  cell_cnt;
    logic [23:0] slot;
    logic        win_full, pre_ok, cell_bit, par_ok;
    logic        acquire, code_err, sub_done;

    // Patterns all start high, so folding on the first half-cell handles both polarities.
    function automatic pre_t classify(input logic [7:0] w);
        logic [7:0] a;
        a = w[7] ? w : ~w;
        case (a)
            8'b11101000: return PT_Z;
            8'b11100100: return PT_Y;
            8'b11100010: return PT_X;
            default:     return PT_NONE;
        endcase
    endfunction

`ifdef RX_SYNC_EN
    logic [2:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], rx_i};
    end
    assign rx_in = sync_q[2];
`else
    assign rx_in = rx_i;
`endif

    assign win_n    = {win[6:0], rx_q};
    assign win_type = classify(win_n);
    assign win_full = (win_cnt == 3'd7);
    assign pre_ok   = (cur_type == PT_Y) ? (win_type == PT_X || win_type == PT_Z)
                                         : (win_type == PT_Y);
    assign cell_bit = h0_q ^ rx_q;
    assign par_ok   = ~(par ^ cell_bit);

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        acquire  = 1'b0;
        code_err = 1'b0;
        sub_done = 1'b0;
        case (state)
            HUNT: if (win_full && win_type != PT_NONE) begin
                state_n = DATA;
                acquire = 1'b1;
            end
            DATA: if (!half) begin
                if (rx_q == last_hc) begin
                    code_err = 1'b1;
                    state_n  = HUNT;
                end
            end else if (cell_cnt == 5'd27) begin
                sub_done = 1'b1;
                state_n  = PRE;
            end
            PRE: if (win_full) begin
                if (pre_ok) begin
                    state_n = DATA;
                    acquire = 1'b1;
                end else begin
                    code_err = 1'b1;
                    state_n  = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q          <= 1'b0;
            last_hc       <= 1'b0;
            win           <= '0;
            win_cnt       <= '0;
            h0_q          <= 1'b0;
            half          <= 1'b0;
            par           <= 1'b0;
            cell_cnt      <= '0;
            slot          <= '0;
            vb            <= 1'b0;
            ub            <= 1'b0;
            cb            <= 1'b0;
            cur_type      <= PT_NONE;
            have_left     <= 1'b0;
            left          <= '0;
            sample_o      <= '0;
            valid_o       <= 1'b0;
            block_start_o <= 1'b0;
            vbit_o        <= '0;
            ubit_o        <= '0;
            cbit_o        <= '0;
            frame_idx_o   <= '0;
            locked_o      <= 1'b0;
            parity_err_o  <= 1'b0;
            code_err_o    <= 1'b0;
        end else begin
            rx_q         <= rx_in;
            last_hc      <= rx_q;
            win          <= win_n;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            code_err_o   <= code_err;

            // The window only fills outside DATA; a failed match restarts it empty.
            if (state == DATA || acquire || code_err) win_cnt <= '0;
            else if (!win_full)                       win_cnt <= win_cnt + 3'd1;

            if (code_err) begin
                locked_o  <= 1'b0;
                have_left <= 1'b0;
            end else if (acquire) begin
                locked_o <= 1'b1;
            end

            if (acquire) begin
                cur_type <= win_type;
                half     <= 1'b0;
                cell_cnt <= '0;
                par      <= 1'b0;
            end else if (state == DATA && !code_err) begin
                half <= ~half;
                if (!half) begin
                    h0_q <= rx_q;
                end else begin
                    cell_cnt <= cell_cnt + 5'd1;
                    par      <= par ^ cell_bit;
                    if (cell_cnt < 5'd24) slot <= {cell_bit, slot[23:1]};
                    if (cell_cnt == 5'd24) vb <= cell_bit;
                    if (cell_cnt == 5'd25) ub <= cell_bit;
                    if (cell_cnt == 5'd26) cb <= cell_bit;
                end
            end

            if (sub_done) begin
                parity_err_o <= ~par_ok;
                if (cur_type != PT_Y) begin
                    left      <= '{sample: slot[23 -: SAMPLE_WIDTH], v: vb, u: ub, c: cb,
                                   z: (cur_type == PT_Z), ok: par_ok};
                    have_left <= 1'b1;
                end else begin
                    have_left <= 1'b0;
                    // An orphaned Y or a pair with a bad half is decoded but dropped.
                    if (have_left && left.ok && par_ok) begin
                        valid_o       <= 1'b1;
                        sample_o      <= {slot[23 -: SAMPLE_WIDTH], left.sample};
                        block_start_o <= left.z;
                        vbit_o        <= {vb, left.v};
                        ubit_o        <= {ub, left.u};
                        cbit_o        <= {cb, left.c};
                        frame_idx_o   <= left.z ? 8'd0 :
                                         (frame_idx_o == 8'd191) ? 8'd0 : frame_idx_o + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spdif_aes3_receiver.sv
// Bench for spdif_aes3_receiver: a BMC stream with injected faults drives a 24-bit and a 16-bit instance.
`timescale 1ns/1ps
module tb_spdif_aes3_receiver;
`ifdef RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 0;
`endif
    localparam int MAXN = 27000;
    localparam int OFF  = 20;
    localparam int PZ = 0, PY = 1, PX = 2;

    typedef struct {
        int          t;
        logic [23:0] slot;
        logic        v, u, c;
        int          flip;
        int          badh0;
    } sf_t;

    typedef struct packed {
        logic [23:0] r, l;
        logic        bs;
        logic [1:0]  v, u, c;
        logic [7:0]  fi;
    } pair_t;

    logic clk = 1'b0, rst = 1'b1, rx_i = 1'b0;
    always #5 clk = ~clk;

    logic [47:0] a_sample; logic [31:0] b_sample;
    logic a_valid, a_bs, a_lock, a_perr, a_cerr, b_valid, b_bs, b_lock, b_perr, b_cerr;
    logic [1:0] a_v, a_u, a_c, b_v, b_u, b_c;
    logic [7:0] a_fi, b_fi;

    spdif_aes3_receiver #(.SAMPLE_WIDTH(24)) dut_a (
        .clk(clk), .rst(rst), .rx_i(rx_i), .sample_o(a_sample), .valid_o(a_valid),
        .block_start_o(a_bs), .vbit_o(a_v), .ubit_o(a_u), .cbit_o(a_c), .frame_idx_o(a_fi),
        .locked_o(a_lock), .parity_err_o(a_perr), .code_err_o(a_cerr));

    spdif_aes3_receiver #(.SAMPLE_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .rx_i(rx_i), .sample_o(b_sample), .valid_o(b_valid),
        .block_start_o(b_bs), .vbit_o(b_v), .ubit_o(b_u), .cbit_o(b_c), .frame_idx_o(b_fi),
        .locked_o(b_lock), .parity_err_o(b_perr), .code_err_o(b_cerr));

    sf_t   sfs[$];
    pair_t pairs[$];
    logic  stream[MAXN];
    int    ns = 0;
    logic  lvl = 1'b0;
    bit    e_val[MAXN], e_perr[MAXN], e_cerr[MAXN], e_lock[MAXN];
    int    e_lkev[MAXN], e_pair[MAXN];

    int n_pass = 0, n_tot = 0;
    int hc_idx = 0;
    bit run = 1'b0;
    int nval = 0, first_val = -1, first_perr = -1, first_cerr = -1, first_lock = -1;
    logic [31:0] first_s16 = '0;
    pair_t cur = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at half-cell %0d: got %0h, expected %0h", nm, hc_idx, act, exp);
    endtask

    task automatic put(input logic b);
        stream[ns] = b;
        ns++;
        lvl = b;
    endtask

    task automatic add(input int t, input logic [23:0] slot, input int flip, input int badh0);
        sf_t s;
        s.t = t; s.slot = slot; s.flip = flip; s.badh0 = badh0;
        s.v = 1'($urandom); s.u = 1'($urandom); s.c = 1'($urandom);
        sfs.push_back(s);
    endtask

    function automatic logic [23:0] rnd24();
        return 24'($urandom);
    endfunction

    // Biphase-mark line coding of one subframe, continuing from the current line level.
    task automatic encode(input sf_t s);
        logic [27:0] b;
        logic [7:0]  p;
        logic        h0, h1;
        b = {^{s.c, s.u, s.v, s.slot}, s.c, s.u, s.v, s.slot};
        p = (s.t == PZ) ? 8'hE8 : (s.t == PY) ? 8'hE4 : 8'hE2;
        if (lvl) p = ~p;
        for (int i = 7; i >= 0; i--) put(p[i]);
        for (int i = 0; i < 28; i++) begin
            h0 = (i == s.badh0) ? lvl : ~lvl;
            h1 = b[i] ? ~h0 : h0;
            if (i == s.flip) h1 = ~h1;
            put(h0);
            put(h1);
        end
    endtask

    // Subframe-level model: decides per subframe what the receiver must report, keyed by half-cell.
    task automatic model();
        bit locked = 0, hl = 0, lok = 0, ok;
        int prev = -1, s;
        logic [27:0] bits;
        pair_t lp, pr;
        logic [7:0] fi = 8'd0;
        bit lvl_now = 0;
        lp = '0;
        for (int k = 1; k < sfs.size(); k++) begin
            s = 64 * k;
            if (!locked) begin
                locked = 1;
                e_lkev[s + 7] = 1;
            end else if ((prev == PY) ? (sfs[k].t == PY) : (sfs[k].t != PY)) begin
                e_cerr[s + 7] = 1; e_lkev[s + 7] = 2;
                locked = 0; hl = 0;
                continue;
            end
            prev = sfs[k].t;
            if (sfs[k].badh0 >= 0) begin
                e_cerr[s + 8 + 2 * sfs[k].badh0] = 1; e_lkev[s + 8 + 2 * sfs[k].badh0] = 2;
                locked = 0; hl = 0;
                continue;
            end
            bits = {^{sfs[k].c, sfs[k].u, sfs[k].v, sfs[k].slot}, sfs[k].c, sfs[k].u, sfs[k].v, sfs[k].slot};
            if (sfs[k].flip >= 0) bits[sfs[k].flip] = ~bits[sfs[k].flip];
            ok = ~(^bits);
            if (!ok) e_perr[s + 63] = 1;
            if (sfs[k].t != PY) begin
                hl = 1; lok = ok;
                lp.l = sfs[k].slot; lp.bs = (sfs[k].t == PZ);
                lp.v[0] = sfs[k].v; lp.u[0] = sfs[k].u; lp.c[0] = sfs[k].c;
            end else begin
                if (hl && lok && ok) begin
                    fi = lp.bs ? 8'd0 : 8'((int'(fi) + 1) % 192);
                    pr = lp;
                    pr.r = sfs[k].slot; pr.fi = fi;
                    pr.v[1] = sfs[k].v; pr.u[1] = sfs[k].u; pr.c[1] = sfs[k].c;
                    pairs.push_back(pr);
                    e_val[s + 63] = 1;
                    e_pair[s + 63] = pairs.size() - 1;
                end
                hl = 0;
            end
        end
        for (int i = 0; i < MAXN; i++) begin
            if (e_lkev[i] == 1) lvl_now = 1;
            if (e_lkev[i] == 2) lvl_now = 0;
            e_lock[i] = lvl_now;
        end
    endtask

    always @(negedge clk) begin : compare
        int j;
        if (run) begin
            j = hc_idx - 2 - LAT;
            if (j >= 0 && j < MAXN) begin
                if (e_val[j]) cur = pairs[e_pair[j]];
                chk("valid24", 64'(a_valid), 64'(e_val[j]));
                chk("valid16", 64'(b_valid), 64'(e_val[j]));
                chk("parity_err24", 64'(a_perr), 64'(e_perr[j]));
                chk("parity_err16", 64'(b_perr), 64'(e_perr[j]));
                chk("code_err24", 64'(a_cerr), 64'(e_cerr[j]));
                chk("code_err16", 64'(b_cerr), 64'(e_cerr[j]));
                chk("locked24", 64'(a_lock), 64'(e_lock[j]));
                chk("locked16", 64'(b_lock), 64'(e_lock[j]));
                chk("sample24", 64'(a_sample), 64'({cur.r, cur.l}));
                chk("sample16", 64'(b_sample), 64'({cur.r[23:8], cur.l[23:8]}));
                chk("block_start", 64'({a_bs, b_bs}), 64'({cur.bs, cur.bs}));
                chk("vuc_bits", 64'({a_v, a_u, a_c}), 64'({cur.v, cur.u, cur.c}));
                chk("vuc_bits16", 64'({b_v, b_u, b_c}), 64'({cur.v, cur.u, cur.c}));
                chk("frame_idx", 64'({a_fi, b_fi}), 64'({cur.fi, cur.fi}));
            end
            if (b_valid) begin
                nval++;
                if (first_val < 0) begin first_val = hc_idx; first_s16 = b_sample; end
            end
            if (a_perr && first_perr < 0) first_perr = hc_idx;
            if (a_cerr && first_cerr < 0) first_cerr = hc_idx;
            if (a_lock && first_lock < 0) first_lock = hc_idx;
        end
    end

    initial begin
        // 0: partial Z (entry 20 half-cells in), 1: orphan Y.
        add(PZ, rnd24(), -1, -1);   add(PY, rnd24(), -1, -1);
        add(PZ, 24'hABCD5A, -1, -1); add(PY, 24'h123499, -1, -1);
        add(PX, rnd24(), -1, -1);   add(PY, rnd24(), -1, -1);
        add(PX, 24'h123456, 5, -1); add(PY, rnd24(), -1, -1);
        add(PX, rnd24(), -1, -1);   add(PY, rnd24(), -1, -1);
        add(PX, rnd24() | 24'h60, -1, 6); add(PY, rnd24(), -1, -1);
        add(PX, rnd24(), -1, -1);   add(PY, rnd24(), -1, -1);
        add(PX, rnd24(), -1, -1);   add(PX, rnd24(), -1, -1);
        add(PZ, rnd24(), -1, -1);   add(PY, rnd24(), -1, -1);
        for (int f = 0; f < 193; f++) begin
            add((f % 192 == 0) ? PZ : PX, rnd24(), -1, -1);
            add(PY, rnd24(), -1, -1);
        end
        foreach (sfs[k]) encode(sfs[k]);
        model();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sample24", 64'(a_sample), 64'd0);
        chk("reset_flags", 64'({a_valid, a_bs, a_lock, a_perr, a_cerr, a_v, a_u, a_c}), 64'd0);
        chk("reset_frame_idx", 64'(a_fi), 64'd0);
        rst = 1'b0;
        for (int n = OFF; n < ns + 3 + LAT; n++) begin
            rx_i   = (n < ns) ? stream[n] : lvl;
            hc_idx = n;
            run    = 1'b1;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1 run = 1'b0;

        chk("valid_count", 64'(nval), 64'd198);
        chk("first_valid_time", 64'(first_val), 64'(257 + LAT));
        chk("first_pair16", 64'(first_s16), 64'h1234ABCD);
        chk("first_parity_err_time", 64'(first_perr), 64'(449 + LAT));
        chk("first_code_err_time", 64'(first_cerr), 64'(662 + LAT));
        chk("first_lock_time", 64'(first_lock), 64'(73 + LAT));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
